pc_sequencer: RTL

Registered program-counter unit for the single-cycle/multi-cycle datapath, replacing the free-standing +4 and immediate-branch adders with one parametrised block. Each cycle it selects the next PC from: sequential, PC-relative branch, absolute jump, call, or return. Calls push a return address onto an internal circular return-address stack (RAS). It sits at the front of fetch; its `pc` output drives instruction-memory address.

---
 rtl/pc_pkg.sv | 16 +
 rtl/return_stack.sv | 86 ++++++++
 rtl/pc_sequencer.sv | 90 +++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter sequencer.
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_SEQ,
        SEL_BRANCH,
        SEL_JUMP,
        SEL_CALL,
        SEL_RET
    } next_sel_t;

    localparam int DEFAULT_INSN_BYTES = 4;
    localparam int DEFAULT_IMM_SHIFT  = 2;

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack: a push while full overwrites the oldest entry.
module return_stack
    import pc_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(RAS_DEPTH):0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]    ptr_reg, ptr_next, top_idx;
    logic [CW-1:0]    count_reg, count_next;
    logic             full_reg, empty_reg, overflow_reg, underflow_reg;
    logic             wr_en;

    // ptr_reg is the next write slot, so the newest entry sits just below it.
    assign top_idx = ptr_reg - PW'(1);
    // Asynchronous read: a ret must see the top in the same cycle it is decided.
    assign top     = mem[top_idx];
    assign wr_en   = push && !pop;

    always_comb begin
        ptr_next   = ptr_reg;
        count_next = count_reg;
        if (pop) begin
            if (count_reg != '0) begin
                ptr_next   = top_idx;
                count_next = count_reg - CW'(1);
            end
        end else if (push) begin
            ptr_next = ptr_reg + PW'(1);
            if (count_reg != DEPTH_C)
                count_next = count_reg + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            ptr_reg       <= '0;
            count_reg     <= '0;
            empty_reg     <= 1'b1;
            full_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            ptr_reg       <= ptr_next;
            count_reg     <= count_next;
            empty_reg     <= (count_next == '0);
            full_reg      <= (count_next == DEPTH_C);
            overflow_reg  <= wr_en && (count_reg == DEPTH_C);
            underflow_reg <= pop && (count_reg == '0);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < RAS_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (wr_en && (ptr_reg == PW'(gi)))
                    mem[gi] <= push_data;
            end
        end
    endgenerate

    assign count     = count_reg;
    assign full      = full_reg;
    assign empty     = empty_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter: selects sequential, branch, jump, call or return each cycle.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = '0,
    parameter int               INSN_BYTES = DEFAULT_INSN_BYTES,
    parameter int               IMM_SHIFT  = DEFAULT_IMM_SHIFT,
    parameter int               RAS_DEPTH  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_imm,
    input  logic             jump,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] jump_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_overflow,
    output logic             ras_underflow
);

    next_sel_t                  sel;
    logic [WIDTH-1:0]           pc_reg, pc_next;
    logic [WIDTH-1:0]           branch_off, branch_target;
    logic [WIDTH-1:0]           ras_top;
    logic [$clog2(RAS_DEPTH):0] ras_count;
    logic                       ras_push, ras_pop;

    assign pc_plus4      = pc_reg + WIDTH'(INSN_BYTES);
    assign branch_off    = branch_imm << IMM_SHIFT;
    assign branch_target = pc_plus4 + branch_off;

    always_comb begin
        sel = SEL_SEQ;
        if (stall)             sel = SEL_HOLD;
        else if (ret)          sel = SEL_RET;
        else if (call)         sel = SEL_CALL;
        else if (jump)         sel = SEL_JUMP;
        else if (branch_taken) sel = SEL_BRANCH;
    end

    always_comb begin
        pc_next = pc_plus4;
        case (sel)
            SEL_HOLD:   pc_next = pc_reg;
            SEL_BRANCH: pc_next = branch_target;
            SEL_JUMP,
            SEL_CALL:   pc_next = jump_target;
            // An empty stack falls through to the next instruction.
            SEL_RET:    pc_next = (ras_count == '0) ? pc_plus4 : ras_top;
            default:    pc_next = pc_plus4;
        endcase
    end

    assign ras_push = (sel == SEL_CALL);
    assign ras_pop  = (sel == SEL_RET);

    always_ff @(posedge clk) begin
        if (reset)
            pc_reg <= RESET_PC;
        else
            pc_reg <= pc_next;
    end

    return_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .srst      (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .count     (ras_count),
        .full      (ras_full),
        .empty     (ras_empty),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );

    assign pc = pc_reg;

endmodule
